// File: rtl/rk_spi_pkg.sv
// rk_spi_master shared definitions: register map, FSM encoding,
// status bit positions and reset constants.
package rk_spi_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_ABT  = 2;

  localparam logic [7:0] RX_RESET = 8'hFF;

endpackage

// File: rtl/rk_spi_clkdiv.sv
// SCK half-period timer: reloads from div while stopped or at each
// tick, so divider writes land on the next half-period boundary.
module rk_spi_clkdiv
  import rk_spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rk_spi_master.sv
// Byte SPI master (mode 0, MSB first) for the RK86 I/O window.
// Optional RK_SPI_AUTOREAD_EN: a DATA read in IDLE starts an 8'hFF transfer.
module rk_spi_master
  import rk_spi_pkg::*;
#(
  parameter int NUM_CS    = 2,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 62
) (
  input  logic              CLK,
  input  logic              N_RESET,
  input  logic [1:0]        I_ADDR,
  input  logic [7:0]        I_DATA,
  input  logic              I_WR,
  input  logic              I_RD,
  output logic [7:0]        O_DATA,
  output logic              O_BUSY,
  output logic              O_DONE,
  input  logic              HOLD,
  input  logic              SPI_MISO,
  output logic              SPI_MOSI,
  output logic              SPI_SCK,
  output logic [NUM_CS-1:0] SPI_NCS
);

  spi_state_t state, state_n;

  logic [7:0]        shift_q;
  logic [7:0]        rx_sh_q;
  logic [7:0]        rx_q;
  logic [2:0]        bit_cnt;
  logic [DIV_W-1:0]  div_q;
  logic [NUM_CS-1:0] cs_q;
  logic              sck_q;
  logic              mosi_q;
  logic              ovr_q;
  logic              abt_q;
  logic              done_q;

  logic idle, busy, run, tick;
  logic wr_ctrl, wr_data, wr_div, rd_stat;
  logic auto_go, start, abort, ovr_set;
  logic sample, shift_en;
  logic [7:0] tx_load;
  logic [7:0] stat;

  assign idle    = (state == ST_IDLE);
  assign busy    = !idle;
  assign run     = (state == ST_SETUP) || (state == ST_HIGH) ||
                   (state == ST_LOW);

  assign wr_ctrl = I_WR && (I_ADDR == ADDR_CTRL);
  assign wr_data = I_WR && (I_ADDR == ADDR_DATA);
  assign wr_div  = I_WR && (I_ADDR == ADDR_DIV);
  assign rd_stat = I_RD && (I_ADDR == ADDR_STAT);

`ifdef RK_SPI_AUTOREAD_EN
  logic rd_data;
  assign rd_data = I_RD && (I_ADDR == ADDR_DATA);
  assign auto_go = rd_data && !wr_data;
  assign tx_load = wr_data ? I_DATA : 8'hFF;
`else
  assign auto_go = 1'b0;
  assign tx_load = I_DATA;
`endif

  assign start   = idle && !HOLD && (wr_data || auto_go);
  assign abort   = HOLD && busy;
  assign ovr_set = ((wr_data || wr_ctrl) && busy) ||
                   (wr_data && HOLD);

  rk_spi_clkdiv #(
    .DIV_W(DIV_W)
  ) u_clkdiv (
    .clk    (CLK),
    .n_reset(N_RESET),
    .run    (run),
    .div    (div_q),
    .tick   (tick)
  );

  always_ff @(posedge CLK) begin
    if (!N_RESET) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sample   = 1'b0;
    shift_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_SETUP;
      end
      ST_SETUP, ST_LOW: begin
        if (tick) begin
          sample  = 1'b1;
          state_n = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          shift_en = 1'b1;
          state_n  = (bit_cnt == 3'd7) ? ST_DONE : ST_LOW;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n  = ST_IDLE;
      sample   = 1'b0;
      shift_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      shift_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= RX_RESET;
      bit_cnt <= '0;
      div_q   <= DIV_W'(DIV_RESET);
      cs_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      ovr_q   <= 1'b0;
      abt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE) && !abort;
      if (wr_div) div_q <= I_DATA[DIV_W-1:0];
      if (wr_ctrl && idle) cs_q <= I_DATA[NUM_CS-1:0];
      // a same-cycle set beats the STAT read clear
      if (ovr_set)      ovr_q <= 1'b1;
      else if (rd_stat) ovr_q <= 1'b0;
      if (abort)        abt_q <= 1'b1;
      else if (rd_stat) abt_q <= 1'b0;
      if (abort) begin
        sck_q  <= 1'b0;
        mosi_q <= 1'b1;
      end else begin
        if (start) begin
          shift_q <= tx_load;
          mosi_q  <= tx_load[7];
          bit_cnt <= '0;
        end
        if (sample) begin
          sck_q   <= 1'b1;
          rx_sh_q <= {rx_sh_q[6:0], SPI_MISO};
        end
        if (shift_en) begin
          sck_q   <= 1'b0;
          shift_q <= {shift_q[6:0], 1'b0};
          mosi_q  <= (bit_cnt == 3'd7) ? 1'b1 : shift_q[6];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == ST_DONE) begin
          rx_q   <= rx_sh_q;
          mosi_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat            = '0;
    stat[STAT_BUSY] = busy;
    stat[STAT_OVR]  = ovr_q;
    stat[STAT_ABT]  = abt_q;
  end

  always_comb begin
    O_DATA = '0;
    unique case (I_ADDR)
      ADDR_CTRL: O_DATA = 8'(cs_q);
      ADDR_DATA: O_DATA = rx_q;
      ADDR_DIV:  O_DATA = 8'(div_q);
      ADDR_STAT: O_DATA = stat;
      default:   O_DATA = '0;
    endcase
  end

  assign O_BUSY   = busy;
  assign O_DONE   = done_q;
  assign SPI_SCK  = sck_q && !HOLD;
  assign SPI_MOSI = HOLD ? 1'b1 : mosi_q;
  assign SPI_NCS  = HOLD ? '1 : ~cs_q;

endmodule

// File: tb/tb_rk_spi_master.sv
// Scoreboard bench for rk_spi_master with a mode-0 slave model.
// Honours RK_SPI_AUTOREAD_EN the same way the design does.
module tb_rk_spi_master;
  import rk_spi_pkg::*;

  logic       CLK = 1'b0;
  logic       N_RESET;
  logic [1:0] I_ADDR;
  logic [7:0] I_DATA;
  logic       I_WR, I_RD, HOLD;
  logic [7:0] O_DATA;
  logic       O_BUSY, O_DONE;
  logic       SPI_MISO, SPI_MOSI, SPI_SCK;
  logic [1:0] SPI_NCS;

  always #5 CLK = ~CLK;

  rk_spi_master dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .I_ADDR  (I_ADDR),
    .I_DATA  (I_DATA),
    .I_WR    (I_WR),
    .I_RD    (I_RD),
    .O_DATA  (O_DATA),
    .O_BUSY  (O_BUSY),
    .O_DONE  (O_DONE),
    .HOLD    (HOLD),
    .SPI_MISO(SPI_MISO),
    .SPI_MOSI(SPI_MOSI),
    .SPI_SCK (SPI_SCK),
    .SPI_NCS (SPI_NCS)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         done_cyc;
    int         hi_len;
    logic [1:0] ncs;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int passes = 0;
  int checks = 0;
  logic [7:0] model_rx;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // mode-0 slave: present next MISO bit after each SCK fall
  logic [7:0] slv_tx, mosi_cap;
  int rises, rise_cyc, hi_len;
  logic sck_prev = 1'b0;

  assign SPI_MISO = slv_tx[7];

  always @(negedge CLK) begin
    if (SPI_SCK && !sck_prev) begin
      mosi_cap = {mosi_cap[6:0], SPI_MOSI};
      rises++;
      rise_cyc = cyc;
    end
    if (!SPI_SCK && sck_prev) begin
      slv_tx = {slv_tx[6:0], 1'b1};
      hi_len = cyc - rise_cyc;
    end
    sck_prev = SPI_SCK;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (O_DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("mosi_byte", mosi_cap, e.tx);
        chk("rx_data", O_DATA, e.rx);
        chk("done_cycle", cyc, e.done_cyc);
        chk("sck_high", hi_len, e.hi_len);
        chk("ncs", SPI_NCS, e.ncs);
        chk("bit_count", rises, 8);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    I_ADDR = a; I_DATA = d; I_WR = 1'b1;
    tick();
    I_WR = 1'b0; I_ADDR = ADDR_DATA;
  endtask

  task automatic rd(logic [1:0] a, output logic [7:0] d);
    I_ADDR = a; I_RD = 1'b1;
    #1 d = O_DATA;
    tick();
    I_RD = 1'b0; I_ADDR = ADDR_DATA;
  endtask

  task automatic arm(logic [7:0] m);
    slv_tx = m; mosi_cap = '0; rises = 0;
  endtask

  task automatic expect_xfer(logic [7:0] tx, logic [7:0] m,
                             int div, logic [1:0] cs);
    sb.push_back('{tx, m, cyc + 1 + 16 * (div + 1) + 1,
                   div + 1, ~cs});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (O_BUSY && n < 3000) begin
      tick(); n++;
    end
    chk("busy_timeout", O_BUSY, 0);
    tick(2);
  endtask

  task automatic xfer(logic [7:0] tx, logic [7:0] m,
                      int div, logic [1:0] cs);
    arm(m);
    expect_xfer(tx, m, div, cs);
    wr(ADDR_DATA, tx);
    wait_idle();
    model_rx = m;
  endtask

  task automatic chk_idle_pins(string tag);
    chk({tag, "_sck"}, SPI_SCK, 0);
    chk({tag, "_mosi"}, SPI_MOSI, 1);
    chk({tag, "_ncs"}, SPI_NCS, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, tx, m;
    int dv;
    logic [1:0] cs;

    N_RESET = 1'b0; I_ADDR = ADDR_DATA; I_DATA = '0;
    I_WR = 1'b0; I_RD = 1'b0; HOLD = 1'b0;
    arm(8'hFF);
    model_rx = RX_RESET;
    tick(3);
    chk_idle_pins("rst");
    chk("rst_busy", O_BUSY, 0);
    chk("rst_done", O_DONE, 0);
    N_RESET = 1'b1;
    tick();
    rd(ADDR_DIV, d);  chk("rst_div", d, 62);
    rd(ADDR_DATA, d); chk("rst_rx", d, 8'hFF);
    rd(ADDR_STAT, d); chk("rst_stat", d, 0);
    rd(ADDR_CTRL, d); chk("rst_ctrl", d, 0);

    // default divider: 63-clock half periods
    m = 8'($urandom);
    arm(m);
    expect_xfer(8'h00, m, 62, 2'b00);
    wr(ADDR_DATA, 8'h00);
    tick(10);
    rd(ADDR_STAT, d); chk("stat_busy", d, 8'h01);
    wait_idle();
    model_rx = m;

    wr(ADDR_DIV, 8'd0);
    wr(ADDR_CTRL, 8'h01);
    xfer(8'hA5, 8'h3C, 0, 2'b01);
    rd(ADDR_DATA, d); chk("rx_3c", d, 8'h3C);

    for (int i = 0; i < 12; i++) begin
      dv = $urandom_range(0, 3);
      cs = 2'($urandom_range(0, 3));
      tx = 8'($urandom);
      m  = 8'($urandom);
      wr(ADDR_DIV, 8'(dv));
      wr(ADDR_CTRL, 8'(cs));
      xfer(tx, m, dv, cs);
      rd(ADDR_DATA, d); chk("rand_rx", d, model_rx);
    end

    // overrun: second DATA write 5 clocks into the first transfer
    wr(ADDR_DIV, 8'd3);
    wr(ADDR_CTRL, 8'h01);
    m = 8'($urandom);
    arm(m);
    expect_xfer(8'h11, m, 3, 2'b01);
    wr(ADDR_DATA, 8'h11);
    tick(4);
    wr(ADDR_DATA, 8'h22);
    wait_idle();
    model_rx = m;
    rd(ADDR_STAT, d); chk("ovr_stat", d, 8'h02);
    rd(ADDR_STAT, d); chk("ovr_clear", d, 8'h00);

    // loader hold aborts a live transfer
    arm(8'($urandom));
    wr(ADDR_DATA, 8'($urandom));
    tick(19);
    HOLD = 1'b1;
    #1 chk_idle_pins("hold");
    tick();
    chk("hold_busy", O_BUSY, 0);
    rd(ADDR_STAT, d); chk("hold_abt", d, 8'h04);
    rd(ADDR_DATA, d); chk("hold_rx", d, model_rx);
    wr(ADDR_DATA, 8'h77);
    rd(ADDR_STAT, d); chk("hold_ovr", d, 8'h02);
    tick(80);
    HOLD = 1'b0;
    #1 chk("hold_release_ncs", SPI_NCS, 2'b10);
    tick();

`ifdef RK_SPI_AUTOREAD_EN
    wr(ADDR_DIV, 8'd0);
    arm(8'hFF);
    expect_xfer(8'hFF, 8'hFF, 0, 2'b01);
    rd(ADDR_DATA, d); chk("auto_old_rx", d, model_rx);
    wait_idle();
    model_rx = 8'hFF;
    rd(ADDR_DATA, d); chk("auto_new_rx", d, 8'hFF);
`else
    wr(ADDR_DIV, 8'd0);
    arm(8'hFF);
    rd(ADDR_DATA, d); chk("noauto_rx", d, model_rx);
    chk("noauto_busy", O_BUSY, 0);
    tick(40);
`endif

    // synchronous reset mid-transfer
    wr(ADDR_DIV, 8'd3);
    arm(8'($urandom));
    wr(ADDR_DATA, 8'h5A);
    tick(10);
    N_RESET = 1'b0;
    tick();
    chk_idle_pins("mid_rst");
    chk("mid_rst_busy", O_BUSY, 0);
    chk("mid_rst_done", O_DONE, 0);
    N_RESET = 1'b1;
    tick();
    rd(ADDR_DIV, d);  chk("mid_rst_div", d, 62);
    rd(ADDR_DATA, d); chk("mid_rst_rx", d, 8'hFF);

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
